// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the Y86 fetch stage: icode constants, RNONE and FSM states.
// The HALTED state exists only when FETCH_HALT_LOCK_EN is defined.
// Included by fetch_unit and its length-decode sub-module.
package fetch_unit_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVL = 4'h2;
    localparam logic [3:0] IIRMOVL = 4'h3;
    localparam logic [3:0] IRMMOVL = 4'h4;
    localparam logic [3:0] IMRMOVL = 4'h5;
    localparam logic [3:0] IOPL    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHL  = 4'hA;
    localparam logic [3:0] IPOPL   = 4'hB;

    localparam logic [3:0] RNONE   = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_BYTE0  = 3'd1,
        S_REGS   = 3'd2,
        S_CONST  = 3'd3
`ifdef FETCH_HALT_LOCK_EN
        , S_HALTED = 3'd4
`endif
    } state_t;

endpackage

// File: rtl/fetch_unit_instr_len_decode.sv
// Maps an icode to its instruction-length flags {need_regids, need_valC, invalid}.
// Latency: purely combinational.
// Backpressure: none; no handshake.
module fetch_unit_instr_len_decode
    import fetch_unit_pkg::*;
(
    input  logic [3:0] i_icode,
    output logic       o_need_regids,
    output logic       o_need_valc,
    output logic       o_invalid
);

    // Length flags per icode; anything above IPOPL is invalid and fetched as 1 byte.
    always_comb begin
        o_need_regids = 1'b0;
        o_need_valc   = 1'b0;
        o_invalid     = 1'b0;
        case (i_icode)
            IHALT, INOP, IRET: begin
            end
            IRRMOVL, IOPL, IPUSHL, IPOPL: begin
                o_need_regids = 1'b1;
            end
            IIRMOVL, IRMMOVL, IMRMOVL: begin
                o_need_regids = 1'b1;
                o_need_valc   = 1'b1;
            end
            IJXX, ICALL: begin
                o_need_valc   = 1'b1;
            end
            default: begin
                o_invalid     = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Multi-cycle Y86 fetch: one byte per memory handshake, delivers registered decoded fields with a done pulse.
// Latency: zero-wait memory gives done n+1 cycles after start for an n-byte instruction; each wait cycle adds one.
// Backpressure: imem_req/imem_addr are held until imem_ack; start is ignored while busy. Macro FETCH_HALT_LOCK_EN adds HALTED lock.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int DATA_WID = 32
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                start,
    input  logic [DATA_WID-1:0] pc_in,
    output logic                imem_req,
    output logic [DATA_WID-1:0] imem_addr,
    input  logic [7:0]          imem_rdata,
    input  logic                imem_ack,
    output logic [3:0]          icode,
    output logic [3:0]          ifun,
    output logic [3:0]          rA,
    output logic [3:0]          rB,
    output logic [DATA_WID-1:0] valC,
    output logic [DATA_WID-1:0] valP,
    output logic                instr_invalid,
    output logic                done,
    output logic                busy
);

    localparam int         NB        = DATA_WID / 8;
    localparam logic [2:0] LAST_BYTE = 3'(NB - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_done_nxt;
    logic                r_imem_req;
    logic [DATA_WID-1:0] r_imem_addr;
    logic [DATA_WID-1:0] r_pc;
    logic [3:0]          r_icode;
    logic [3:0]          r_ifun;
    logic [3:0]          r_ra;
    logic [3:0]          r_rb;
    logic [DATA_WID-1:0] r_valc;
    logic [DATA_WID-1:0] r_valp;
    logic                r_invalid;
    logic                r_done;
    logic [2:0]          r_cnt;

    logic                w_ack;
    logic [3:0]          w_dec_icode;
    logic                w_need_regids;
    logic                w_need_valc;
    logic                w_invalid;
    logic [3:0]          w_len;

    // An ack only counts while a request is outstanding.
    assign w_ack       = imem_ack & r_imem_req;
    // In BYTE0 the icode is still on the memory bus; afterwards it is held in r_icode.
    assign w_dec_icode = (r_state == S_BYTE0) ? imem_rdata[7:4] : r_icode;
    assign w_len       = 4'd1 + {3'd0, w_need_regids} + (w_need_valc ? 4'(NB) : 4'd0);

    fetch_unit_instr_len_decode instr_len_decode (
        .i_icode       (w_dec_icode),
        .o_need_regids (w_need_regids),
        .o_need_valc   (w_need_valc),
        .o_invalid     (w_invalid)
    );

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state and done decode; each fetch state advances only on an ack.
    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_BYTE0;
            end
            S_BYTE0: begin
                if (w_ack) begin
                    if (w_need_regids) begin
                        w_state_nxt = S_REGS;
                    end else if (w_need_valc) begin
                        w_state_nxt = S_CONST;
                    end else begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_IDLE;
`ifdef FETCH_HALT_LOCK_EN
                        if (w_dec_icode == IHALT || w_invalid) w_state_nxt = S_HALTED;
`endif
                    end
                end
            end
            S_REGS: begin
                if (w_ack) begin
                    if (w_need_valc) begin
                        w_state_nxt = S_CONST;
                    end else begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_CONST: begin
                if (w_ack && r_cnt == LAST_BYTE) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
`ifdef FETCH_HALT_LOCK_EN
            S_HALTED: begin
                w_state_nxt = S_HALTED;
            end
`endif
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Memory request, address and captured fields; fields change only on a capturing ack.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_imem_req  <= 1'b0;
            r_imem_addr <= '0;
            r_pc        <= '0;
            r_icode     <= 4'h0;
            r_ifun      <= 4'h0;
            r_ra        <= RNONE;
            r_rb        <= RNONE;
            r_valc      <= '0;
            r_valp      <= '0;
            r_invalid   <= 1'b0;
            r_done      <= 1'b0;
            r_cnt       <= 3'd0;
        end else begin
            r_done     <= w_done_nxt;
            r_imem_req <= (w_state_nxt == S_BYTE0) || (w_state_nxt == S_REGS) ||
                          (w_state_nxt == S_CONST);
            if (r_state == S_IDLE && start) begin
                r_pc        <= pc_in;
                r_imem_addr <= pc_in;
            end else if (w_ack) begin
                r_imem_addr <= r_imem_addr + DATA_WID'(1);
            end
            if (w_ack) begin
                case (r_state)
                    S_BYTE0: begin
                        r_icode   <= imem_rdata[7:4];
                        r_ifun    <= imem_rdata[3:0];
                        r_ra      <= RNONE;
                        r_rb      <= RNONE;
                        r_valc    <= '0;
                        r_invalid <= w_invalid;
                        r_valp    <= r_pc + DATA_WID'(w_len);
                        r_cnt     <= 3'd0;
                    end
                    S_REGS: begin
                        r_ra <= imem_rdata[7:4];
                        r_rb <= imem_rdata[3:0];
                    end
                    S_CONST: begin
                        r_valc[{r_cnt, 3'b000} +: 8] <= imem_rdata;
                        r_cnt                        <= r_cnt + 3'd1;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign imem_req      = r_imem_req;
    assign imem_addr     = r_imem_addr;
    assign icode         = r_icode;
    assign ifun          = r_ifun;
    assign rA            = r_ra;
    assign rB            = r_rb;
    assign valC          = r_valc;
    assign valP          = r_valp;
    assign instr_invalid = r_invalid;
    assign done          = r_done;
    assign busy          = (r_state == S_BYTE0) || (r_state == S_REGS) || (r_state == S_CONST);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: byte-wide memory model with programmable wait states.
// Latency: done cycle counted from the start cycle (cycle 0).
// Backpressure: memory model stalls ack by wait_n cycles per byte.
module tb_fetch_unit;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        start = 1'b0;
    logic [31:0] pc_in = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [7:0]  imem_rdata;
    logic        imem_ack;
    logic [3:0]  icode, ifun, rA, rB;
    logic [31:0] valC, valP;
    logic        instr_invalid, done, busy;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mem [0:1023];
    logic [3:0]  wait_n = 4'd0;
    logic [3:0]  w_cnt = 4'd0;
    logic [31:0] acked [$];
    logic        held = 1'b0;
    logic [31:0] held_addr = 32'h0;
    logic        moved = 1'b0;

    fetch_unit #(.DATA_WID(32)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .start         (start),
        .pc_in         (pc_in),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .imem_ack      (imem_ack),
        .icode         (icode),
        .ifun          (ifun),
        .rA            (rA),
        .rB            (rB),
        .valC          (valC),
        .valP          (valP),
        .instr_invalid (instr_invalid),
        .done          (done),
        .busy          (busy)
    );

    always #5 CLK = ~CLK;

    assign imem_rdata = mem[imem_addr[9:0]];
    assign imem_ack   = imem_req && (w_cnt == wait_n);

    // Wait-state counter, acked-address log and address-stability monitor.
    always @(posedge CLK) begin
        if (imem_req && imem_ack) w_cnt <= 4'd0;
        else if (imem_req)        w_cnt <= w_cnt + 4'd1;
        else                      w_cnt <= 4'd0;
        if (imem_req && imem_ack) acked.push_back(imem_addr);
        if (imem_req && held && imem_addr != held_addr) moved <= 1'b1;
        held      <= imem_req && !imem_ack;
        held_addr <= imem_addr;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_fetch(input logic [31:0] pc, input int budget, output int cyc);
        @(negedge CLK);
        start = 1'b1;
        pc_in = pc;
        @(negedge CLK);
        start = 1'b0;
        cyc   = 1;
        while (done !== 1'b1 && cyc < budget) begin
            @(negedge CLK);
            cyc++;
        end
        if (done !== 1'b1) cyc = -1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req"},   imem_req, 0);
        chk({tag, "_addr"},  imem_addr, 0);
        chk({tag, "_icode"}, icode, 0);
        chk({tag, "_ifun"},  ifun, 0);
        chk({tag, "_rA"},    rA, 4'hF);
        chk({tag, "_rB"},    rB, 4'hF);
        chk({tag, "_valC"},  valC, 0);
        chk({tag, "_valP"},  valP, 0);
        chk({tag, "_inv"},   instr_invalid, 0);
        chk({tag, "_done"},  done, 0);
        chk({tag, "_busy"},  busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cyc;
        logic        saw_req;
        logic [31:0] exp_addr [5];

        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        mem[10'h100] = 8'h10;
        mem[10'h020] = 8'h30; mem[10'h021] = 8'hF3; mem[10'h022] = 8'h78;
        mem[10'h023] = 8'h56; mem[10'h024] = 8'h34; mem[10'h025] = 8'h12;
        mem[10'h040] = 8'h20; mem[10'h041] = 8'h12;
        mem[10'h3FE] = 8'h70; mem[10'h3FF] = 8'h44;
        mem[10'h000] = 8'h33; mem[10'h001] = 8'h22; mem[10'h002] = 8'h11;
        mem[10'h080] = 8'hC0;
        mem[10'h200] = 8'h70; mem[10'h201] = 8'h11; mem[10'h202] = 8'h22;
        mem[10'h203] = 8'h33; mem[10'h204] = 8'h44;

        // Reset values.
        #2 RST = 1'b1;
        #1 chk_reset_vals("rst");
        repeat (2) @(negedge CLK);
        RST = 1'b0;

        // nop at 0x100: 1 byte, done in cycle 2, one-cycle pulse.
        do_fetch(32'h100, 20, cyc);
        chk("nop_cyc",   cyc, 2);
        chk("nop_icode", icode, 4'h1);
        chk("nop_rA",    rA, 4'hF);
        chk("nop_rB",    rB, 4'hF);
        chk("nop_valC",  valC, 0);
        chk("nop_valP",  valP, 32'h101);
        chk("nop_inv",   instr_invalid, 0);
        @(negedge CLK);
        chk("nop_pulse", done, 0);
        chk("nop_hold",  valP, 32'h101);

        // irmovl at 0x20, zero-wait: 6 bytes, done in cycle 7.
        do_fetch(32'h20, 30, cyc);
        chk("irm_cyc",   cyc, 7);
        chk("irm_icode", icode, 4'h3);
        chk("irm_ifun",  ifun, 4'h0);
        chk("irm_rA",    rA, 4'hF);
        chk("irm_rB",    rB, 4'h3);
        chk("irm_valC",  valC, 32'h12345678);
        chk("irm_valP",  valP, 32'h26);
        chk("irm_req",   imem_req, 0);
        chk("irm_busy",  busy, 0);

        // rrmovl at 0x40 with 2 wait cycles per byte: done in cycle 7, address stable.
        wait_n = 4'd2;
        moved  = 1'b0;
        do_fetch(32'h40, 30, cyc);
        chk("rr_cyc",    cyc, 7);
        chk("rr_icode",  icode, 4'h2);
        chk("rr_rA",     rA, 4'h1);
        chk("rr_rB",     rB, 4'h2);
        chk("rr_valC",   valC, 0);
        chk("rr_valP",   valP, 32'h42);
        chk("rr_stable", moved, 0);
        wait_n = 4'd0;

        // jmp at 0xFFFFFFFE: address wraps, valP wraps to 3.
        acked.delete();
        do_fetch(32'hFFFFFFFE, 30, cyc);
        exp_addr = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0, 32'h1, 32'h2};
        chk("jmp_cyc",   cyc, 6);
        chk("jmp_icode", icode, 4'h7);
        chk("jmp_valC",  valC, 32'h11223344);
        chk("jmp_valP",  valP, 32'h3);
        chk("jmp_nacks", acked.size(), 5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("jmp_addr%0d", i), (acked.size() > i) ? acked[i] : 32'hDEAD, exp_addr[i]);
        end

        // Invalid icode 0xC at 0x80: length 1, fields forced.
        do_fetch(32'h80, 20, cyc);
        chk("inv_cyc",   cyc, 2);
        chk("inv_flag",  instr_invalid, 1);
        chk("inv_icode", icode, 4'hC);
        chk("inv_rA",    rA, 4'hF);
        chk("inv_rB",    rB, 4'hF);
        chk("inv_valC",  valC, 0);
        chk("inv_valP",  valP, 32'h81);

`ifdef FETCH_HALT_LOCK_EN
        // Locked: a further start is ignored.
        @(negedge CLK);
        start = 1'b1;
        pc_in = 32'h100;
        @(negedge CLK);
        start   = 1'b0;
        saw_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (imem_req || busy || done) saw_req = 1'b1;
            @(negedge CLK);
        end
        chk("lock_idle", saw_req, 0);
        chk("lock_valP", valP, 32'h81);
`else
        // Not locked: the next start fetches normally.
        saw_req = 1'b0;
        do_fetch(32'h100, 20, cyc);
        chk("post_inv_cyc",  cyc, 2);
        chk("post_inv_flag", instr_invalid, 0);
        chk("post_inv_valP", valP, 32'h101);
`endif

        // Reset pulse clears everything regardless of mode.
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;

        // Reset mid-CONST after 2 of 4 constant bytes.
        @(negedge CLK);
        start = 1'b1;
        pc_in = 32'h200;
        @(negedge CLK);
        start = 1'b0;
        repeat (3) @(negedge CLK);
        chk("mid_busy", busy, 1);
        chk("mid_req",  imem_req, 1);
        chk("mid_valC", valC, 32'h2211);
        RST = 1'b1;
        #1 chk_reset_vals("midrst");
        @(negedge CLK);
        RST = 1'b0;
        do_fetch(32'h200, 30, cyc);
        chk("refetch_cyc",   cyc, 6);
        chk("refetch_icode", icode, 4'h7);
        chk("refetch_valC",  valC, 32'h44332211);
        chk("refetch_valP",  valP, 32'h205);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
